jk_reg_bank: RTL
================

Name: jk_reg_bank

Overview:
- Parametrised WIDTH-bit JK register bank, the next generation of the single-bit JK flip-flop.
- Per-bit J/K control, plus three word-level modes: synchronous up-count, down-count and parallel load.
- Adds a terminal-count flag and a per-bit change report.
- Used as a general state/counter primitive in the logic-design lab datapaths.

Parameters:
- WIDTH, 4, number of JK cells (>=1).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  mode-operation enable; when low, q holds (sclr/sset still act).
- mode  input  2  00 JK, 01 count up, 10 count down, 11 parallel load.
- j  input  WIDTH  per-bit J (MODE_JK only).
- k  input  WIDTH  per-bit K (MODE_JK only).
- d  input  WIDTH  load data (MODE_LOAD only).
- sclr  input  1  synchronous clear-all.
- sset  input  1  synchronous set-all.
- q  output  WIDTH  register state.
- qb  output  WIDTH  ~q, combinational.
- tc  output  1  terminal count, combinational.
- chg  output  WIDTH  registered; bits of q that changed on the last clock edge.

Behaviour:
- Reset asserted (asynchronous, any time): q=RESET_VAL, chg=0 immediately; qb=~RESET_VAL.
- Reset deasserts between edges; the first update occurs on the next rising edge.
- Each rising edge, with reset low, the first matching rule below applies:
  1. sclr=1: q<=0. sclr wins when sclr and sset are both 1.
  2. sset=1: q<=all-ones.
  3. en=0: q holds.
  4. MODE_JK, per bit i:
     - j=0,k=0: hold.
     - j=0,k=1: 0.
     - j=1,k=0: 1.
     - j=1,k=1: toggle.
  5. MODE_UP: q<=q+1 modulo 2^WIDTH; all-ones wraps to 0.
  6. MODE_DN: q<=q-1 modulo 2^WIDTH; 0 wraps to all-ones.
  7. MODE_LOAD: q<=d.
- chg<=q_next^q on every edge, including sclr/sset edges; chg=0 on hold cycles.
- Latency: one edge from inputs to q. qb and tc follow q combinationally.
- tc=1 when:
  - mode=UP and q=all-ones, or
  - mode=DN and q=0.
  - Otherwise tc=0. tc is independent of en.
- Mode may change every cycle; no history is kept across mode changes.
- WIDTH=1: UP and DN both reduce to toggle.

Optional Feature:
- Macro: JK_SAT_EN.
- When defined:
  - UP holds at all-ones instead of wrapping; DN holds at 0 instead of wrapping.
  - Extra output sat (1 bit, registered, reset 0). sat<=1 on an edge where a count was blocked by saturation, otherwise 0.
  - chg=0 on a blocked edge.
- When undefined: wrap-around as above; the sat port is absent.

Decomposition:
- Package jk_pkg:
  - mode constants MODE_JK=2'b00, MODE_UP=2'b01, MODE_DN=2'b10, MODE_LOAD=2'b11.
  - a 2-bit mode typedef.
- Sub-module jk_cell: combinational next-state of one JK bit (q, j, k -> q_next). Instantiated WIDTH times for MODE_JK.
- The top level owns mode muxing, count arithmetic, priority, registers, chg, tc and sat.

Test Plan:
- Reset mid-cycle with q=4'hA: assert reset between edges -> q=4'h0, qb=4'hF, chg=0 without waiting for a clock edge.
- MODE_JK, q=4'b0101, j=4'b1100, k=4'b1010, en=1 -> after the edge q=4'b1101, chg=4'b1000. Then j=k=4'hF -> q=4'b0010, chg=4'b1111.
- MODE_UP from q=4'hE:
  - edges: q=4'hF with tc=1, then q=4'h0 with chg=4'hF.
  - under JK_SAT_EN: q stays 4'hF, sat=1, chg=0.
- MODE_DN from 4'h1 -> 4'h0 with tc=1, then 4'hF (wrap). Set en=0 -> q holds 4'hF, tc=0 (mode still DN, q not 0).
- sclr=1 and sset=1 together with en=0, q=4'h6 -> q=4'h0, chg=4'h6. Next cycle sset only -> q=4'hF.
- MODE_LOAD d=4'h9 then mode=JK with j=k=0 -> q=4'h9 and holds, chg=0 on the hold edge.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared definitions for the JK register bank: the mode encoding and its type.
package jk_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_JK   = 2'b00;
    localparam mode_t MODE_UP   = 2'b01;
    localparam mode_t MODE_DN   = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Next-state logic of a single JK bit: hold, reset, set or toggle.
module jk_cell (
    input  logic q,
    input  logic j,
    input  logic k,
    output logic q_next
);

    // Classic JK truth table; j=k=1 toggles the stored bit.
    always_comb begin
        q_next = q;
        case ({j, k})
            2'b00:   q_next = q;
            2'b01:   q_next = 1'b0;
            2'b10:   q_next = 1'b1;
            default: q_next = ~q;
        endcase
    end

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit JK register bank with per-bit JK control, up/down counting,
// parallel load, synchronous clear/set, terminal count and change report.
// Optional feature macro JK_SAT_EN: counts saturate instead of wrapping and
// a registered sat flag reports edges on which a count was blocked.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    input  logic             sclr,
    input  logic             sset,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic [WIDTH-1:0] chg
`ifdef JK_SAT_EN
    ,
    output logic             sat
`endif
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] jk_next;
    logic [WIDTH-1:0] q_next;
    logic             blocked;

    // Increment; with saturation enabled all-ones is sticky.
    function automatic logic [WIDTH-1:0] count_up(input logic [WIDTH-1:0] v);
`ifdef JK_SAT_EN
        if (v == ALL_ONES) return v;
`endif
        return v + ONE;
    endfunction

    // Decrement; with saturation enabled zero is sticky.
    function automatic logic [WIDTH-1:0] count_dn(input logic [WIDTH-1:0] v);
`ifdef JK_SAT_EN
        if (v == ALL_ZERO) return v;
`endif
        return v - ONE;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_cell u_cell (
                .q      (q[gi]),
                .j      (j[gi]),
                .k      (k[gi]),
                .q_next (jk_next[gi])
            );
        end
    endgenerate

    // Priority select of the next state: clear, set, hold, then the mode.
    always_comb begin
        q_next  = q;
        blocked = 1'b0;
        if (sclr) begin
            q_next = ALL_ZERO;
        end else if (sset) begin
            q_next = ALL_ONES;
        end else if (en) begin
            case (mode)
                MODE_JK: q_next = jk_next;
                MODE_UP: begin
                    q_next = count_up(q);
`ifdef JK_SAT_EN
                    blocked = (q == ALL_ONES);
`endif
                end
                MODE_DN: begin
                    q_next = count_dn(q);
`ifdef JK_SAT_EN
                    blocked = (q == ALL_ZERO);
`endif
                end
                default: q_next = d;
            endcase
        end
    end

    // State and change-report registers; a blocked count yields q_next == q,
    // so chg naturally reads zero on that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q   <= RESET_VAL;
            chg <= ALL_ZERO;
        end else begin
            q   <= q_next;
            chg <= q_next ^ q;
        end
    end

`ifdef JK_SAT_EN
    // Saturation flag: high for one cycle after an edge whose count was held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sat <= 1'b0;
        else       sat <= blocked;
    end
`else
    logic unused_blocked;
    assign unused_blocked = blocked;
`endif

    assign qb = ~q;
    assign tc = ((mode == MODE_UP) && (q == ALL_ONES)) ||
                ((mode == MODE_DN) && (q == ALL_ZERO));

endmodule
